// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display stage.
// Glyphs are active-high {g,f,e,d,c,b,a}.
package alu_disp_pkg;

  localparam int NUM_DIGITS   = 3;
  localparam int RES_W        = 6;
  localparam int DABBLE_ITERS = 6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  typedef enum logic [1:0] {
    KIND_DIGIT,
    KIND_OP,
    KIND_BLANK
  } glyph_kind_e;

  localparam logic [6:0] GLYPH_D0    = 7'h3F;
  localparam logic [6:0] GLYPH_D1    = 7'h06;
  localparam logic [6:0] GLYPH_D2    = 7'h5B;
  localparam logic [6:0] GLYPH_D3    = 7'h4F;
  localparam logic [6:0] GLYPH_D4    = 7'h66;
  localparam logic [6:0] GLYPH_D5    = 7'h6D;
  localparam logic [6:0] GLYPH_D6    = 7'h7D;
  localparam logic [6:0] GLYPH_D7    = 7'h07;
  localparam logic [6:0] GLYPH_D8    = 7'h7F;
  localparam logic [6:0] GLYPH_D9    = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_H     = 7'h76;
  localparam logic [6:0] GLYPH_LD    = 7'h5E;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational glyph encoder: a 4-bit code plus a glyph kind to segments.
// Out-of-range digit codes render blank rather than garbage.
module seg7_encode
  import alu_disp_pkg::*;
(
  input  logic [3:0] code,
  input  logic [1:0] kind,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    case (kind)
      KIND_DIGIT: begin
        case (code)
          4'd0:    seg = GLYPH_D0;
          4'd1:    seg = GLYPH_D1;
          4'd2:    seg = GLYPH_D2;
          4'd3:    seg = GLYPH_D3;
          4'd4:    seg = GLYPH_D4;
          4'd5:    seg = GLYPH_D5;
          4'd6:    seg = GLYPH_D6;
          4'd7:    seg = GLYPH_D7;
          4'd8:    seg = GLYPH_D8;
          4'd9:    seg = GLYPH_D9;
          default: seg = GLYPH_BLANK;
        endcase
      end
      KIND_OP: begin
        case (code[1:0])
          2'b00:   seg = GLYPH_A;
          2'b01:   seg = GLYPH_DASH;
          2'b10:   seg = GLYPH_H;
          default: seg = GLYPH_LD;
        endcase
      end
      default: seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_display.sv
// ALU result display: multi-cycle binary-to-BCD conversion with a one-deep
// pending slot, feeding a 3-digit multiplexed seven-segment scan.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [RES_W-1:0]      res_in,
  input  logic [1:0]            op_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  busy,
  output logic                  done
);

  localparam int                CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam int                ITER_W    = $clog2(DABBLE_ITERS + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DABBLE_ITERS - 1);

  state_e             state_q, state_d;
  logic [RES_W-1:0]   bin_q, bin_d;
  logic [7:0]         bcd_q, bcd_d;
  logic [7:0]         bcd_adj;
  logic [1:0]         op_q, op_d;
  logic [ITER_W-1:0]  iter_q, iter_d;

  logic               pend_valid_q, pend_valid_d;
  logic [RES_W-1:0]   pend_res_q, pend_res_d;
  logic [1:0]         pend_op_q, pend_op_d;

  logic [3:0]         shadow_tens_q, shadow_tens_d;
  logic [3:0]         shadow_ones_q, shadow_ones_d;
  logic [1:0]         shadow_op_q, shadow_op_d;

  logic               start_req;
  logic [RES_W-1:0]   start_res;
  logic [1:0]         start_op;

  logic [CNT_W-1:0]      refresh_q;
  logic                  scan_wrap;
  logic [NUM_DIGITS-1:0] dig_sel_q, sel_next;
  logic [6:0]            seg_q, seg_enc;
  logic [3:0]            scan_code;
  glyph_kind_e           scan_kind;
  logic                  busy_q, done_q;

  assign bcd_adj = {dabble_adjust(bcd_q[7:4]), dabble_adjust(bcd_q[3:0])};

  // A live load always beats a queued one; the pending slot only feeds a restart from COMMIT.
  assign start_req = load || ((state_q == COMMIT) && pend_valid_q);
  assign start_res = load ? res_in : pend_res_q;
  assign start_op  = load ? op_in  : pend_op_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    bcd_d         = bcd_q;
    op_d          = op_q;
    iter_d        = iter_q;
    pend_valid_d  = pend_valid_q;
    pend_res_d    = pend_res_q;
    pend_op_d     = pend_op_q;
    shadow_tens_d = shadow_tens_q;
    shadow_ones_d = shadow_ones_q;
    shadow_op_d   = shadow_op_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = res_in;
          op_d    = op_in;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d         = iter_q + 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = COMMIT;
        end
        if (load) begin
          pend_valid_d = 1'b1;
          pend_res_d   = res_in;
          pend_op_d    = op_in;
        end
      end

      COMMIT: begin
        shadow_tens_d = bcd_q[7:4];
        shadow_ones_d = bcd_q[3:0];
        shadow_op_d   = op_q;
        pend_valid_d  = 1'b0;
        if (start_req) begin
          bin_d   = start_res;
          op_d    = start_op;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q         <= '0;
      bcd_q         <= '0;
      op_q          <= '0;
      iter_q        <= '0;
      pend_valid_q  <= 1'b0;
      pend_res_q    <= '0;
      pend_op_q     <= '0;
      shadow_tens_q <= '0;
      shadow_ones_q <= '0;
      shadow_op_q   <= '0;
    end else begin
      bin_q         <= bin_d;
      bcd_q         <= bcd_d;
      op_q          <= op_d;
      iter_q        <= iter_d;
      pend_valid_q  <= pend_valid_d;
      pend_res_q    <= pend_res_d;
      pend_op_q     <= pend_op_d;
      shadow_tens_q <= shadow_tens_d;
      shadow_ones_q <= shadow_ones_d;
      shadow_op_q   <= shadow_op_d;
    end
  end

  // The glyph is chosen from the digit about to be selected so seg and dig_sel change together.
  always_comb begin
    scan_wrap = (refresh_q == CNT_LAST);
    sel_next  = scan_wrap ? {dig_sel_q[NUM_DIGITS-2:0], dig_sel_q[NUM_DIGITS-1]} : dig_sel_q;
    scan_code = '0;
    scan_kind = KIND_BLANK;
    case (sel_next)
      3'b001: begin
        scan_code = shadow_ones_q;
        scan_kind = KIND_DIGIT;
      end
      3'b010: begin
        scan_code = shadow_tens_q;
        scan_kind = (shadow_tens_q == 4'd0) ? KIND_BLANK : KIND_DIGIT;
      end
      3'b100: begin
        scan_code = {2'b00, shadow_op_q};
        scan_kind = KIND_OP;
      end
      default: begin
        scan_code = '0;
        scan_kind = KIND_BLANK;
      end
    endcase
  end

  seg7_encode u_seg7_encode (
    .code (scan_code),
    .kind (scan_kind),
    .seg  (seg_enc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_q <= '0;
      dig_sel_q <= NUM_DIGITS'(1);
      seg_q     <= GLYPH_BLANK;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      refresh_q <= scan_wrap ? '0 : refresh_q + 1'b1;
      dig_sel_q <= sel_next;
      seg_q     <= seg_enc;
      busy_q    <= (state_q != IDLE);
      done_q    <= (state_q == COMMIT);
    end
  end

  assign seg     = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dig_sel = dig_sel_q ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Randomized bench for alu_result_display against a transaction-level model:
// decimal digits by division, 7-edge latency, latest-wins pending slot, scan by edge count.
module tb_alu_result_display;

  localparam int REFRESH_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] res_in;
  logic [1:0] op_in;
  logic       load;
  logic [6:0] seg;
  logic [2:0] dig_sel;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  bit m_active;
  int m_left;
  int m_val, m_op;
  bit m_pend;
  int m_pend_val, m_pend_op;
  int m_show_val, m_show_op;
  int m_scan_k;

  logic [6:0] exp_seg;
  logic [2:0] exp_dig;
  logic       exp_busy, exp_done;

  always #5 clk = ~clk;

  alu_result_display #(
    .REFRESH_DIV    (REFRESH_DIV),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .res_in  (res_in),
    .op_in   (op_in),
    .load    (load),
    .seg     (seg),
    .dig_sel (dig_sel),
    .busy    (busy),
    .done    (done)
  );

  function automatic logic [6:0] digitGlyph(input int d);
    logic [6:0] table_d [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return table_d[d];
  endfunction

  function automatic logic [6:0] opGlyph(input int o);
    logic [6:0] table_o [4] = '{7'h77, 7'h40, 7'h76, 7'h5E};
    return table_o[o];
  endfunction

  function automatic logic [6:0] expectedSeg(input int pos, input int val, input int op);
    if (pos == 0) return digitGlyph(val % 10);
    if (pos == 1) return (val / 10 == 0) ? 7'h00 : digitGlyph(val / 10);
    return opGlyph(op);
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %02h, expected %02h", tag, cycle, observed, expected);
    end
  endtask

  task automatic modelStart(input int v, input int o);
    m_active = 1'b1;
    m_left   = 7;
    m_val    = v;
    m_op     = o;
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic modelEdge(input bit r, input bit ld, input int rv, input int ov);
    int prev_val = m_show_val;
    int prev_op  = m_show_op;
    int pos;
    bit was_active;
    if (!r) begin
      m_active = 1'b0; m_pend = 1'b0;
      m_show_val = 0; m_show_op = 0; m_scan_k = 0;
      exp_seg = 7'h00; exp_dig = 3'b001; exp_busy = 1'b0; exp_done = 1'b0;
      return;
    end
    was_active = m_active;
    exp_done   = 1'b0;
    if (was_active) begin
      m_left--;
      if (m_left == 0) begin
        m_show_val = m_val;
        m_show_op  = m_op;
        exp_done   = 1'b1;
        if (ld) begin
          modelStart(rv, ov);
          m_pend = 1'b0;
        end else if (m_pend) begin
          modelStart(m_pend_val, m_pend_op);
          m_pend = 1'b0;
        end else begin
          m_active = 1'b0;
        end
      end else if (ld) begin
        m_pend     = 1'b1;
        m_pend_val = rv;
        m_pend_op  = ov;
      end
    end else if (ld) begin
      modelStart(rv, ov);
    end
    exp_busy = was_active;
    m_scan_k++;
    pos     = (m_scan_k / REFRESH_DIV) % 3;
    exp_dig = 3'b001 << pos;
    exp_seg = expectedSeg(pos, prev_val, prev_op);
  endtask

  task automatic applyStimulus(input bit r, input bit ld, input int rv, input int ov);
    rst_n  = r;
    load   = ld;
    res_in = rv[5:0];
    op_in  = ov[1:0];
    @(posedge clk);
    cycle++;
    modelEdge(r, ld, rv, ov);
    @(negedge clk);
    checkOutput("seg",     {1'b0, seg},     {1'b0, exp_seg});
    checkOutput("dig_sel", {5'b0, dig_sel}, {5'b0, exp_dig});
    checkOutput("busy",    {7'b0, busy},    {7'b0, exp_busy});
    checkOutput("done",    {7'b0, done},    {7'b0, exp_done});
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    res_in = '0;
    op_in  = '0;
    @(negedge clk);

    // Reset for three cycles, one of them with load high, which must be ignored.
    applyStimulus(1'b0, 1'b1, 45, 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    idleCycles(14);

    applyStimulus(1'b1, 1'b1, 45, 0);
    idleCycles(16);
    applyStimulus(1'b1, 1'b1, 7, 3);
    idleCycles(16);
    applyStimulus(1'b1, 1'b1, 63, 1);
    idleCycles(16);
    applyStimulus(1'b1, 1'b1, 10, 2);
    idleCycles(16);
    applyStimulus(1'b1, 1'b1, 0, 2);
    idleCycles(16);

    // Pending slot: the later of two queued loads wins.
    applyStimulus(1'b1, 1'b1, 12, 0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b1, 30, 1);
    applyStimulus(1'b1, 1'b1, 50, 2);
    idleCycles(20);

    // Reset mid-conversion aborts it.
    applyStimulus(1'b1, 1'b1, 20, 3);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 0, 0);
    idleCycles(14);

    // Load exactly in the COMMIT cycle with an empty pending slot.
    applyStimulus(1'b1, 1'b1, 5, 1);
    idleCycles(6);
    applyStimulus(1'b1, 1'b1, 33, 2);
    idleCycles(16);

    // Load in COMMIT while the pending slot is full: the live load wins.
    applyStimulus(1'b1, 1'b1, 9, 0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b1, 41, 1);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 58, 3);
    idleCycles(20);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 399) != 0),
                    ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 3)));
    end
    idleCycles(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
